// File: rtl/dig_period_counter.sv
// -----------------------------------------------------------------------------
// dig_period_counter
//
// Period counter for a comparator-based relaxation oscillator readout.
// The block discharges the analog integrator (o_reset high) for RST_CYCLES
// clocks, releases it, and counts clk cycles until the comparator output
// rises. 2^AVG_LOG2 consecutive periods are summed and the truncated mean is
// delivered on a valid/ready result port. A period that reaches the counter
// ceiling without a comparator edge is a timeout: it counts as the ceiling
// value and flags the result as saturated.
//
// Parameters
//   CNT_W      period counter / result width; counter saturates at 2^CNT_W-1
//   RST_CYCLES cycles o_reset is held high per discharge (>= 1)
//   AVG_LOG2   log2 of periods accumulated per result (0 = every period)
//
// Ports
//   i_clk    in   1      system clock
//   i_rst    in   1      synchronous reset, active-high, overrides everything
//   i_en     in   1      measurement enable (0 parks the block in IDLE)
//   i_cmp    in   1      comparator output, 1 = threshold crossed
//   o_reset  out  1      analog discharge switch, 1 = discharging
//   o_data   out  CNT_W  averaged period in clk cycles
//   o_sat    out  1      result contains at least one timed-out period
//   o_valid  out  1      o_data / o_sat valid
//   i_ready  in   1      consumer accepts when o_valid && i_ready
//   o_ovr    out  1      sticky: a result was dropped while o_valid && !i_ready
//
// Configuration macro
//   DIG_CMP_SYNC_EN  when defined, i_cmp passes through a 2-flop synchroniser
//                    before edge detection. Measured periods then read 2
//                    cycles longer and the response moves 2 cycles later.
//                    When undefined, i_cmp must already be synchronous to clk.
// -----------------------------------------------------------------------------
module dig_period_counter #(
  parameter int CNT_W      = 8,
  parameter int RST_CYCLES = 101,
  parameter int AVG_LOG2   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cmp,
  output logic             o_reset,
  output logic [CNT_W-1:0] o_data,
  output logic             o_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_ovr
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  // Accumulator holds 2^AVG_LOG2 periods of at most 2^CNT_W-1, so it never wraps.
  localparam int ACC_W = CNT_W + AVG_LOG2;
  // Keep the period-index and discharge counters at least one bit wide so the
  // degenerate configurations (AVG_LOG2=0, RST_CYCLES=1) stay legal.
  localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [N_W-1:0]   N_LAST   = N_W'((1 << AVG_LOG2) - 1);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DISCH  = 2'd1,
    S_CHARGE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [RC_W-1:0]    r_rcnt;    // discharge cycle counter
  logic [CNT_W-1:0]   r_cnt;     // charge cycle counter (saturating)
  logic [ACC_W-1:0]   r_acc;     // sum of completed periods in this result
  logic [N_W-1:0]     r_n;       // index of the period being measured
  logic               r_psat;    // OR of timeout flags of completed periods
  logic               r_cmp_q;   // previous comparator sample for edge detect
  logic               r_reset;
  logic [CNT_W-1:0]   r_data;
  logic               r_sat;
  logic               r_valid;
  logic               r_ovr;

  // ---------------------------------------------------------------------------
  // Next-state / datapath wires
  // ---------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [RC_W-1:0]    w_rcnt_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [N_W-1:0]     w_n_nxt;
  logic               w_psat_nxt;
  logic [CNT_W-1:0]   w_data_nxt;
  logic               w_sat_nxt;
  logic               w_valid_nxt;
  logic               w_ovr_nxt;
  logic               w_reset_nxt;

  logic               w_cmp_s;    // comparator as seen by the edge detector
  logic               w_cmp_rise;
  logic               w_at_max;
  logic               w_timeout;
  logic               w_event;
  logic               w_last;
  logic               w_result;
  logic [ACC_W-1:0]   w_psum;
  logic [CNT_W-1:0]   w_res_data;
  logic               w_res_sat;

  // ---------------------------------------------------------------------------
  // Comparator conditioning
  // ---------------------------------------------------------------------------
`ifdef DIG_CMP_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_cmp;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cmp_s = r_sync2;
`else
  assign w_cmp_s = i_cmp;
`endif

  // ---------------------------------------------------------------------------
  // Measurement datapath
  // ---------------------------------------------------------------------------
  assign w_cmp_rise = w_cmp_s & ~r_cmp_q;
  assign w_at_max   = (r_cnt == CNT_MAX);
  // A rise on the ceiling cycle is a genuine edge, not a timeout.
  assign w_timeout  = w_at_max & ~w_cmp_rise;
  assign w_event    = (r_state == S_CHARGE) & (w_cmp_rise | w_at_max);
  assign w_last     = (r_n == N_LAST);
  assign w_psum     = r_acc + ACC_W'(r_cnt);
  assign w_res_data = CNT_W'(w_psum >> AVG_LOG2);
  assign w_res_sat  = r_psat | w_timeout;
  // Disabling the block discards an event seen in the same cycle.
  assign w_result   = i_en & w_event & w_last;

  // ---------------------------------------------------------------------------
  // FSM next state and measurement counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its default before the case statement; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_n_nxt     = r_n;
    w_psat_nxt  = r_psat;

    if (!i_en) begin
      // Abandon any partial accumulation and park with the switch closed.
      w_state_nxt = S_IDLE;
      w_rcnt_nxt  = '0;
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
      w_n_nxt     = '0;
      w_psat_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_DISCH;
          w_rcnt_nxt  = '0;
        end

        S_DISCH: begin
          // Comparator is ignored while the integrator is shorted.
          if (r_rcnt == RST_LAST) begin
            w_state_nxt = S_CHARGE;
            w_cnt_nxt   = '0;
          end else begin
            w_rcnt_nxt  = r_rcnt + RC_W'(1);
          end
        end

        S_CHARGE: begin
          if (w_event) begin
            if (w_last) begin
              w_acc_nxt  = '0;
              w_n_nxt    = '0;
              w_psat_nxt = 1'b0;
            end else begin
              w_acc_nxt  = w_psum;
              w_n_nxt    = r_n + N_W'(1);
              w_psat_nxt = w_res_sat;
            end
            w_state_nxt = S_DISCH;
            w_rcnt_nxt  = '0;
          end else begin
            // No event implies the counter is still below its ceiling.
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // The switch is open only while charging; decoding the next state keeps
    // o_reset registered and aligned with the state register.
    w_reset_nxt = (w_state_nxt != S_CHARGE);
  end

  // ---------------------------------------------------------------------------
  // Result port handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    w_data_nxt  = r_data;
    w_sat_nxt   = r_sat;
    w_valid_nxt = r_valid;
    w_ovr_nxt   = r_ovr;

    if (w_result) begin
      if (r_valid && !i_ready) begin
        // Consumer is stalled: keep the pending result, drop the new one.
        w_ovr_nxt = 1'b1;
      end else begin
        // Either nothing pending or the pending result transfers this cycle.
        w_data_nxt  = w_res_data;
        w_sat_nxt   = w_res_sat;
        w_valid_nxt = 1'b1;
      end
    end else if (r_valid && i_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_DISCH;
      r_rcnt  <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_n     <= '0;
      r_psat  <= 1'b0;
      r_cmp_q <= 1'b0;
      r_reset <= 1'b1;
      r_data  <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_n     <= w_n_nxt;
      r_psat  <= w_psat_nxt;
      r_cmp_q <= w_cmp_s;
      r_reset <= w_reset_nxt;
      r_data  <= w_data_nxt;
      r_sat   <= w_sat_nxt;
      r_valid <= w_valid_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign o_reset = r_reset;
  assign o_data  = r_data;
  assign o_sat   = r_sat;
  assign o_valid = r_valid;
  assign o_ovr   = r_ovr;

endmodule
